sa_drain: RTL and testbench
===========================

// Module: sa_drain
// PURPOSE
//  East-edge result collector for the systolic array: reverse of the input skew/buffer chain.
//  Takes per-row HLINK outputs (s,c,z) that leave the array skewed by one cycle per row.
//  De-skews them into a row-aligned vector and queues it in an output FIFO.
//  Presents it on a valid/ready stream; raises hold to the array controller before the FIFO can overflow.
// PARAMETERS
//  ROWS       4   number of array rows / east-edge lanes (>=2)
//  DATA_W     16  width of s per lane, two's complement
//  FIFO_DEPTH 8   output FIFO entries (power of 2, >= ROWS+2)
// PORTS
//  clk        in   1              clock, from the CTRL interface
//  rst        in   1              asynchronous, active-high reset, from the CTRL interface
//  lane_s     in   ROWS*DATA_W    HLINK s per lane; lane r = bits [r*DATA_W +: DATA_W]
//  lane_c     in   ROWS           HLINK c per lane: lane word valid
//  lane_z     in   ROWS           HLINK z per lane: last vector of tile
//  out_valid  out  1              FIFO head valid
//  out_ready  in   1              consumer accepts head
//  out_data   out  ROWS*DATA_W    aligned vector, same lane packing as lane_s
//  out_last   out  1              head carries the tile-last flag
//  hold       out  1              stop array injection (registered)
//  busy       out  1              data in deskew lines or FIFO
//  tile_done  out  1              1-cycle pulse when an out_last entry is handshaken
//  err_ovf    out  1              sticky: push attempted while FIFO full
//  err_align  out  1              sticky: aligned c bits disagree
//  err_clr    in   1              synchronous clear of both sticky errors
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0; deskew registers, FIFO pointers/count, errors cleared.
//  Skew: a vector's lane r word arrives in cycle t+r.
//   Lane r passes through ROWS-1-r registers; lane ROWS-1 passes straight through.
//   All lanes are aligned at the deskew output in cycle t+ROWS-1.
//  Push: in cycle t+ROWS-1, if every aligned c=1, write {s vector, z[0]} into the FIFO.
//  Alignment: aligned c all 0 -> no push, no error.
//   Mixed c -> no push; err_align set next cycle.
//   Aligned c all 1 but z bits differ -> push with last=z[0]; err_align set.
//  Latency: out_valid rises in cycle t+ROWS (FIFO registered, no bypass) when the FIFO was empty.
//  Handshake: pop when out_valid && out_ready.
//   out_data/out_last are stable while out_valid && !out_ready.
//   out_valid never drops without a pop.
//  Simultaneous push+pop: allowed at any count, including full; count unchanged.
//   At full, the entry popped that cycle makes room, so no err_ovf.
//  Full: push without a same-cycle pop is dropped; err_ovf set; FIFO contents untouched.
//  hold: registered; next-cycle value = (free entries after this cycle's push/pop) <= ROWS.
//   Covers up to ROWS-1 words still in the deskew lines.
//  Pointers: log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
//  tile_done: pulses in the cycle after the handshake of an entry with last=1.
//  busy: any deskew stage holds c=1, or count != 0.
//  err_clr in the same cycle as a new error: the error wins and stays set.
//  Deskew lines never stall; upstream must honour hold.
// CONFIGURATION
//  SA_DRAIN_RELU_EN defined: each lane word is clamped to 0 if negative (MSB=1), at FIFO write.
//  SA_DRAIN_RELU_EN undefined: words pass unmodified. Latency is identical either way.
// STRUCTURE
//  Shared package sa_pkg: DATA_W/ROWS defaults, typedef lane_t (logic signed [DATA_W-1:0]),
//   vec_t (lane_t [ROWS-1:0]), typedef drain_entry_t struct {vec_t data; logic last}.
//  Sub-module sa_deskew_line #(DEPTH, W): reset-clearable shift register, DEPTH=0 is a wire.
//   Instantiated once per lane with DEPTH=ROWS-1-r and W=DATA_W+2, carrying {s,c,z}.
//  FIFO storage, pointers, hold/err logic live in sa_drain itself.
// TESTING (ROWS=4, DATA_W=16, FIFO_DEPTH=8)
//  Skewed vector: s=0x0011,0x0022,0x0033,0x0044 in cycles 0..3, c=1 -> cycle 4 out_valid=1,
//   out_data={0044,0033,0022,0011}, out_last=0.
//  out_ready=0, push 4 vectors back to back -> hold=1 the cycle after the 4th push.
//   Continue to 9 pushes -> 8 stored, err_ovf=1; drain yields 8 vectors in order.
//  Full FIFO with push+pop in the same cycle -> count stays 8, err_ovf stays 0.
//  Aligned c={1,1,0,1} -> no push, err_align=1 until err_clr pulse, then 0.
//  Vector with z=1 on all lanes -> out_last=1; tile_done=1 for exactly one cycle after its handshake.
//  rst mid-stream with 3 entries queued -> out_valid, hold, busy=0 immediately.
//   The next fresh vector has latency 4 again.
//  RELU: lane s=0xFFF0 -> 0x0000 with SA_DRAIN_RELU_EN, 0xFFF0 without.

Source files
------------

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared defaults and lane/vector/entry types for the systolic-array drain
// Purpose: default geometry of the east-edge drain and the types consumers use
//   to unpack its output stream at that geometry.
// Ports: none (package).
package sa_pkg;

  localparam int SA_ROWS       = 4;
  localparam int SA_DATA_W     = 16;
  localparam int SA_FIFO_DEPTH = 8;

  typedef logic signed [SA_DATA_W-1:0] lane_t;
  typedef lane_t [SA_ROWS-1:0] vec_t;

  typedef struct packed {
    vec_t data;
    logic last;
  } drain_entry_t;

endpackage

// File: rtl/sa_deskew_line.sv
// rtl/sa_deskew_line.sv - reset-clearable shift register used to re-align one east-edge lane
// Purpose: delays a lane word by DEPTH cycles; DEPTH=0 degenerates to a wire.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   d_i      : word entering the line
//   q_o      : word leaving the line DEPTH cycles later
//   occ_o    : some stage currently holds a word with bit VBIT set
module sa_deskew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 18,
  parameter int VBIT  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         occ_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};
    assign q_o   = d_i;
    assign occ_o = 1'b0;
  end else begin : g_shift
    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    always_comb begin
      occ_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) occ_o = occ_o | stage_q[i][VBIT];
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/sa_drain.sv
// rtl/sa_drain.sv - east-edge de-skew, output FIFO and stream interface of the systolic array
// Purpose: re-aligns per-row HLINK words (s,c,z) that leave the array skewed by
//   one cycle per row, queues complete vectors and presents them on a valid/ready stream.
// Optional feature: SA_DRAIN_RELU_EN clamps negative lane words to 0 at FIFO write.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   lane_s/lane_c/lane_z : skewed HLINK data, word-valid and tile-last per lane
//   out_valid/out_ready  : stream handshake; out_data/out_last carry the FIFO head
//   hold                 : registered request to stop array injection
//   busy                 : words in flight in the deskew lines or the FIFO
//   tile_done            : one-cycle pulse after a last-flagged entry is accepted
//   err_ovf, err_align   : sticky overflow / lane misalignment flags, cleared by err_clr
module sa_drain
  import sa_pkg::*;
#(
  parameter int ROWS       = SA_ROWS,
  parameter int DATA_W     = SA_DATA_W,
  parameter int FIFO_DEPTH = SA_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS*DATA_W-1:0] lane_s,
  input  logic [ROWS-1:0]        lane_c,
  input  logic [ROWS-1:0]        lane_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROWS*DATA_W-1:0] out_data,
  output logic                   out_last,
  output logic                   hold,
  output logic                   busy,
  output logic                   tile_done,
  output logic                   err_ovf,
  output logic                   err_align,
  input  logic                   err_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = DATA_W + 2;

  typedef struct packed {
    logic [ROWS*DATA_W-1:0] data;
    logic                   last;
  } entry_t;

  logic [ROWS*DATA_W-1:0] al_s, wr_data;
  logic [ROWS-1:0]        al_c, al_z, occ;

  // Lane r arrives r cycles late, so it waits ROWS-1-r cycles to line up with lane ROWS-1.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [LW-1:0] line_q;
    sa_deskew_line #(.DEPTH(ROWS-1-r), .W(LW), .VBIT(1)) u_line (
      .clk   (clk),
      .rst   (rst),
      .d_i   ({lane_s[r*DATA_W +: DATA_W], lane_c[r], lane_z[r]}),
      .q_o   (line_q),
      .occ_o (occ[r])
    );
    assign al_s[r*DATA_W +: DATA_W] = line_q[LW-1:2];
    assign al_c[r] = line_q[1];
    assign al_z[r] = line_q[0];
  end

  always_comb begin
    wr_data = al_s;
`ifdef SA_DRAIN_RELU_EN
    for (int r = 0; r < ROWS; r++) begin
      if (al_s[r*DATA_W + DATA_W - 1]) wr_data[r*DATA_W +: DATA_W] = '0;
    end
`else
    wr_data = al_s;
`endif
  end

  entry_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d, free_d;
  logic            hold_q, tile_done_q, err_ovf_q, err_align_q;
  logic            hold_d, err_ovf_d, err_align_d;
  logic            all_c, any_c, z_mis, full, push, pop, push_ok, ovf_set;
  entry_t          head;

  assign all_c = &al_c;
  assign any_c = |al_c;
  // z must agree across lanes of a valid vector; all-0 and all-1 are both consistent.
  assign z_mis = all_c & ~((&al_z) | ~(|al_z));

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push    = all_c;
  assign pop     = out_valid & out_ready;
  // At full, a same-cycle pop frees the slot the push needs.
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  assign count_d = count_q + CW'(push_ok) - CW'(pop);
  assign free_d  = CW'(FIFO_DEPTH) - count_d;
  // Leave room for the up to ROWS-1 vectors still travelling through the deskew lines.
  assign hold_d  = (free_d <= CW'(ROWS));

  // An error raised this cycle outranks a simultaneous clear.
  assign err_ovf_d   = ovf_set | (err_ovf_q & ~err_clr);
  assign err_align_d = (any_c & ~all_c) | z_mis | (err_align_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{data: wr_data, last: al_z[0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= 1'b0;
      tile_done_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      hold_q      <= hold_d;
      tile_done_q <= pop & head.last;
      err_ovf_q   <= err_ovf_d;
      err_align_q <= err_align_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_last  = out_valid & head.last;
  assign hold      = hold_q;
  assign busy      = (|occ) | out_valid;
  assign tile_done = tile_done_q;
  assign err_ovf   = err_ovf_q;
  assign err_align = err_align_q;

endmodule

// File: tb/tb_sa_drain.sv
// tb/tb_sa_drain.sv - self-checking bench for sa_drain with a queue-based reference model
module tb_sa_drain;

  localparam int ROWS  = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [ROWS*DW-1:0]   lane_s = '0;
  logic [ROWS-1:0]      lane_c = '0, lane_z = '0;
  logic                 out_valid, out_last, hold, busy, tile_done, err_ovf, err_align;
  logic                 out_ready = 1'b0, err_clr = 1'b0;
  logic [ROWS*DW-1:0]   out_data;

  sa_drain #(.ROWS(ROWS), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .lane_s(lane_s), .lane_c(lane_c), .lane_z(lane_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .hold(hold), .busy(busy), .tile_done(tile_done), .err_ovf(err_ovf),
    .err_align(err_align), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS*DW-1:0] s;
    logic [ROWS-1:0]    c;
    logic [ROWS-1:0]    z;
  } launch_t;

  typedef struct packed {
    logic [ROWS*DW-1:0] d;
    logic               last;
  } ent_t;

  typedef struct {
    logic [63:0] s;
    logic [3:0]  c;
    logic [3:0]  z;
    logic        ev;
    logic [63:0] ed;
    logic        el;
    logic        ea;
  } vec_case_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: hist[k] is the vector launched k cycles ago, mq the FIFO contents.
  launch_t hist [1:ROWS-1];
  ent_t    mq [$];
  logic    m_hold, m_td, m_ovf, m_aln;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_relu(input logic [63:0] v);
    logic [63:0] o;
    o = v;
`ifdef SA_DRAIN_RELU_EN
    for (int r = 0; r < ROWS; r++) if (o[r*DW+DW-1]) o[r*DW +: DW] = '0;
`endif
    return o;
  endfunction

  function automatic launch_t mkl(input int base);
    launch_t l;
    for (int r = 0; r < ROWS; r++) l.s[r*DW +: DW] = 16'(base * 16 + r + 1);
    l.c = '1;
    l.z = '0;
    return l;
  endfunction

  function automatic logic [63:0] mkd(input int base);
    launch_t l;
    l = mkl(base);
    return l.s;
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int k = 1; k < ROWS; k++) hist[k] = '0;
    m_hold = 0; m_td = 0; m_ovf = 0; m_aln = 0;
  endtask

  task automatic check_outputs();
    logic exp_busy;
    exp_busy = (mq.size() != 0);
    // A word of lane r launched k cycles ago sits in a deskew stage while r < k.
    for (int k = 1; k < ROWS; k++)
      for (int r = 0; r < k; r++)
        if (hist[k].c[r]) exp_busy = 1'b1;
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_data", out_data, mq[0].d);
      chk("out_last", 64'(out_last), 64'(mq[0].last));
    end
    chk("hold", 64'(hold), 64'(m_hold));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("tile_done", 64'(tile_done), 64'(m_td));
    chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
    chk("err_align", 64'(err_align), 64'(m_aln));
  endtask

  // One clock: check current outputs, drive skewed lanes, advance the model.
  task automatic cycle(input launch_t cur, input logic rdy, input logic clr);
    launch_t src, al;
    logic [ROWS*DW-1:0] s_v;
    logic [ROWS-1:0] c_v, z_v;
    logic all_c, any_c, zmis, pop, full, ovf_set;
    ent_t head;
    check_outputs();
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) src = cur; else src = hist[r];
      s_v[r*DW +: DW] = src.s[r*DW +: DW];
      c_v[r] = src.c[r];
      z_v[r] = src.z[r];
    end
    lane_s = s_v; lane_c = c_v; lane_z = z_v;
    out_ready = rdy; err_clr = clr;
    @(posedge clk);
    al    = hist[ROWS-1];
    all_c = &al.c;
    any_c = |al.c;
    zmis  = all_c && !((&al.z) || (al.z == '0));
    full  = (mq.size() == DEPTH);
    pop   = (mq.size() != 0) && rdy;
    head  = (mq.size() != 0) ? mq[0] : '0;
    ovf_set = 1'b0;
    if (pop) void'(mq.pop_front());
    m_td = pop && head.last;
    if (all_c) begin
      if (full && !pop) ovf_set = 1'b1;
      else mq.push_back('{d: m_relu(al.s), last: al.z[0]});
    end
    m_hold = (DEPTH - mq.size()) <= ROWS;
    m_ovf  = ovf_set || (m_ovf && !clr);
    m_aln  = (any_c && !all_c) || zmis || (m_aln && !clr);
    for (int k = ROWS - 1; k > 1; k--) hist[k] = hist[k-1];
    hist[1] = cur;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle('0, rdy, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_hold", 64'(hold), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_tile_done", 64'(tile_done), 0);
    chk("rst_errs", 64'({err_ovf, err_align}), 0);
    chk("rst_out_data", out_data, 0);
    model_clear();
    lane_s = '0; lane_c = '0; lane_z = '0; out_ready = 0; err_clr = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_case_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    launch_t l;
    int lat;
    tbl[0] = '{64'h0044_0033_0022_0011, 4'hF, 4'h0, 1'b1, 64'h0044_0033_0022_0011, 1'b0, 1'b0};
    tbl[1] = '{64'h1111_2222_3333_4444, 4'h0, 4'h0, 1'b0, 64'h0, 1'b0, 1'b0};
    tbl[2] = '{64'h0001_0002_0003_0004, 4'b1101, 4'h0, 1'b0, 64'h0, 1'b0, 1'b1};
    tbl[3] = '{64'h7FFF_0100_0200_0300, 4'hF, 4'hF, 1'b1, 64'h7FFF_0100_0200_0300, 1'b1, 1'b0};
    tbl[4] = '{64'h0A0A_0B0B_0C0C_0D0D, 4'hF, 4'b0101, 1'b1, 64'h0A0A_0B0B_0C0C_0D0D, 1'b1, 1'b1};
`ifdef SA_DRAIN_RELU_EN
    tbl[5] = '{64'h1234_5678_0042_FFF0, 4'hF, 4'h0, 1'b1, 64'h1234_5678_0042_0000, 1'b0, 1'b0};
`else
    tbl[5] = '{64'h1234_5678_0042_FFF0, 4'hF, 4'h0, 1'b1, 64'h1234_5678_0042_FFF0, 1'b0, 1'b0};
`endif

    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single skewed vectors: result visible in cycle t+ROWS.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      l.s = tbl[i].s; l.c = tbl[i].c; l.z = tbl[i].z;
      cycle(l, 1'b0, 1'b0);
      idle(3, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
        chk($sformatf("tbl%0d_last", i), 64'(out_last), 64'(tbl[i].el));
      end
      chk($sformatf("tbl%0d_err_align", i), 64'(err_align), 64'(tbl[i].ea));
    end

    // err_align clears on an err_clr pulse.
    cycle('0, 1'b0, 1'b1);
    chk("err_align_cleared", 64'(err_align), 0);

    // Fill with out_ready low: hold after 4th push, overflow on the 9th.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(mkl(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("hold_after_3", 64'(hold), 0);
    idle(1, 1'b0);
    chk("hold_after_4", 64'(hold), 1);
    for (int i = 4; i < 9; i++) cycle(mkl(i), 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("ovf_flag", 64'(err_ovf), 1);
    chk("ovf_hold", 64'(hold), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), out_data, mkd(i));
      cycle('0, 1'b1, 1'b0);
    end
    chk("drained_empty", 64'(out_valid), 0);

    // Push and pop together while full: no overflow, count stays 8.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(mkl(i), 1'b0, 1'b0);
    idle(3, 1'b0);
    cycle(mkl(20), 1'b0, 1'b0);
    idle(2, 1'b0);
    cycle('0, 1'b1, 1'b0);
    chk("full_pp_ovf", 64'(err_ovf), 0);
    chk("full_pp_hold", 64'(hold), 1);
    for (int i = 1; i < 9; i++) begin
      chk($sformatf("pp_drain%0d", i), out_data, (i == 8) ? mkd(20) : mkd(i));
      cycle('0, 1'b1, 1'b0);
    end
    chk("pp_empty", 64'(out_valid), 0);

    // Tile-last entry: tile_done pulses for one cycle after its handshake.
    do_reset();
    l = mkl(5); l.z = '1;
    cycle(l, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("last_flag", 64'(out_last), 1);
    chk("tile_done_before", 64'(tile_done), 0);
    cycle('0, 1'b1, 1'b0);
    chk("tile_done_pulse", 64'(tile_done), 1);
    cycle('0, 1'b0, 1'b0);
    chk("tile_done_end", 64'(tile_done), 0);

    // Reset mid-stream, then latency of a fresh vector.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(mkl(i + 30), 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("pre_rst_busy", 64'(busy), 1);
    do_reset();
    cycle(mkl(40), 1'b0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 12) begin
      idle(1, 1'b0);
      lat++;
    end
    chk("fresh_latency", 64'(lat), 4);
    chk("fresh_data", out_data, mkd(40));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int p;
      logic rdy;
      p = $urandom_range(0, 9);
      l.s = {$urandom, $urandom};
      if (p < 6)      l.c = '1;
      else if (p < 8) l.c = '0;
      else            l.c = 4'($urandom);
      if ($urandom_range(0, 7) == 0)       l.z = '1;
      else if ($urandom_range(0, 15) == 0) l.z = 4'($urandom);
      else                                 l.z = '0;
      if (i < 300) rdy = ($urandom_range(0, 3) == 0);
      else         rdy = ($urandom_range(0, 3) != 0);
      cycle(l, rdy, ($urandom_range(0, 30) == 0));
    end
    idle(12, 1'b1);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
